// File: rtl/arc4_encrypt.sv
// ARC4 encryption engine: S-box init, key schedule, keystream XOR.
// Writes a length-prefixed ciphertext image from a length-prefixed plaintext.
module arc4_encrypt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);

  typedef enum logic [4:0] {
    IDLE,
    INIT,
    K_RI,
    K_WI,
    K_RJ,
    K_WJ,
    K_WRI,
    K_WRJ,
    L_R,
    L_W,
    L_C,
    P_RI,
    P_WI,
    P_RJ,
    P_WJ,
    P_WRI,
    P_WRJ,
    P_RT,
    P_WT,
    P_CT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [23:0] key_q, key_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [1:0]  k3_q, k3_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  ptk_q, ptk_d;

  logic [7:0]  s_addr_q, s_addr_d;
  logic [7:0]  s_wrdata_q, s_wrdata_d;
  logic        s_wren_q, s_wren_d;
  logic [7:0]  pt_addr_q, pt_addr_d;
  logic [7:0]  ct_addr_q, ct_addr_d;
  logic [7:0]  ct_wrdata_q, ct_wrdata_d;
  logic        ct_wren_q, ct_wren_d;

  logic [7:0]  kb;
  logic [7:0]  j_ksa;
  logic [7:0]  j_prga;

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign pt_addr   = pt_addr_q;
  assign ct_addr   = ct_addr_q;
  assign ct_wrdata = ct_wrdata_q;
  assign ct_wren   = ct_wren_q;

  // Key byte for the current schedule step (i mod 3).
  always_comb begin
    kb = key_q[7:0];
    unique case (k3_q)
      2'd0:    kb = key_q[23:16];
      2'd1:    kb = key_q[15:8];
      default: kb = key_q[7:0];
    endcase
  end

  assign j_ksa  = j_q + s_rddata + kb;
  assign j_prga = j_q + s_rddata;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    k3_d        = k3_q;
    len_d       = len_q;
    k_d         = k_q;
    ptk_d       = ptk_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;
    pt_addr_d   = pt_addr_q;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    ct_wren_d   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (en) begin
          state_d    = INIT;
          key_d      = key;
          i_d        = 8'd0;
          s_addr_d   = 8'd0;
          s_wrdata_d = 8'd0;
          s_wren_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      INIT: begin
        if (i_q == 8'hFF) begin
          state_d  = K_RI;
          i_d      = 8'd0;
          j_d      = 8'd0;
          k3_d     = 2'd0;
          s_addr_d = 8'd0;
        end else begin
          i_d        = i_q + 8'd1;
          s_addr_d   = i_q + 8'd1;
          s_wrdata_d = i_q + 8'd1;
          s_wren_d   = 1'b1;
        end
      end
      K_RI: state_d = K_WI;
      K_WI: begin
        si_d     = s_rddata;
        j_d      = j_ksa;
        s_addr_d = j_ksa;
        state_d  = K_RJ;
      end
      K_RJ: state_d = K_WJ;
      K_WJ: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = K_WRI;
      end
      K_WRI: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        state_d    = K_WRJ;
      end
      K_WRJ: begin
        if (i_q == 8'hFF) begin
          pt_addr_d = 8'd0;
          state_d   = L_R;
        end else begin
          i_d      = i_q + 8'd1;
          k3_d     = (k3_q == 2'd2) ? 2'd0 : k3_q + 2'd1;
          s_addr_d = i_q + 8'd1;
          state_d  = K_RI;
        end
      end
      L_R: state_d = L_W;
      L_W: begin
        len_d       = pt_rddata;
        ct_addr_d   = 8'd0;
        ct_wrdata_d = pt_rddata;
        ct_wren_d   = 1'b1;
        state_d     = L_C;
      end
      L_C: begin
        if (len_q == 8'd0) begin
          state_d = DONE;
        end else begin
          i_d       = 8'd1;
          j_d       = 8'd0;
          k_d       = 8'd1;
          s_addr_d  = 8'd1;
          pt_addr_d = 8'd1;
          state_d   = P_RI;
        end
      end
      P_RI: state_d = P_WI;
      P_WI: begin
        si_d     = s_rddata;
        j_d      = j_prga;
        ptk_d    = pt_rddata;
        s_addr_d = j_prga;
        state_d  = P_RJ;
      end
      P_RJ: state_d = P_WJ;
      P_WJ: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = P_WRI;
      end
      P_WRI: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        state_d    = P_WRJ;
      end
      P_WRJ: begin
        s_addr_d = si_q + sj_q;
        state_d  = P_RT;
      end
      P_RT: state_d = P_WT;
      P_WT: begin
        ct_addr_d   = k_q;
        ct_wrdata_d = ptk_q ^ s_rddata;
        ct_wren_d   = 1'b1;
        state_d     = P_CT;
      end
      P_CT: begin
        if (k_q == len_q) begin
          state_d = DONE;
        end else begin
          i_d       = i_q + 8'd1;
          k_d       = k_q + 8'd1;
          s_addr_d  = i_q + 8'd1;
          pt_addr_d = k_q + 8'd1;
          state_d   = P_RI;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE) || (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      key_q       <= 24'd0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      k3_q        <= 2'd0;
      len_q       <= 8'd0;
      k_q         <= 8'd0;
      ptk_q       <= 8'd0;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      s_wren_q    <= 1'b0;
      pt_addr_q   <= 8'd0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
      ct_wren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      key_q       <= key_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      k3_q        <= k3_d;
      len_q       <= len_d;
      k_q         <= k_d;
      ptk_q       <= ptk_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      pt_addr_q   <= pt_addr_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      ct_wren_q   <= ct_wren_d;
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: behavioural memories, RC4 reference model,
// scoreboard on ciphertext writes.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  s_addr, s_wrdata, s_rddata;
  logic        s_wren;
  logic [7:0]  pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;
  logic        ct_wren;

  arc4_encrypt dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .s_rddata(s_rddata),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];

  // Synchronous 256x8 memories, one-cycle read latency.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int wren_cnt = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  exp_img [256];
  logic [7:0]  ks [256];

  logic [7:0] std_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69,
                              8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] std_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8,
                              8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] ksv_ct [5]  = '{8'h04, 8'hEB, 8'h9F, 8'h77, 8'h81};

  // Monitor: every ciphertext write is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && ct_wren) begin
      wren_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ct_write_unexpected: got addr=%02h data=%02h, none expected",
                 ct_addr, ct_wrdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({ct_addr, ct_wrdata} !== e)
        begin
          failures++;
          $display("FAIL ct_write: got addr=%02h data=%02h expected addr=%02h data=%02h",
                   ct_addr, ct_wrdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  // Counts edges on which a start request is accepted.
  always @(negedge clk) begin
    if (!rst && rdy && en) acc_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_le(input string nm, input int act, input int lim);
    checks++;
    if (act > lim) begin
      failures++;
      $display("FAIL %s: got %0d expected at most %0d", nm, act, lim);
    end
  endtask

  // Reference RC4: keystream byte n (1-based) lands in ks[n].
  task automatic gen_ks(input logic [23:0] k);
    int s [256];
    int kb [3];
    int i, j, t;
    kb[0] = int'(k[23:16]);
    kb[1] = int'(k[15:8]);
    kb[2] = int'(k[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    ks[0] = 8'd0;
    for (int n = 1; n < 256; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[n] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic push_expected(input logic [23:0] k);
    int L;
    gen_ks(k);
    L = int'(pt_mem[0]);
    for (int a = 0; a < 256; a++) exp_img[a] = 8'hAA;
    exp_img[0] = pt_mem[0];
    exp_q.push_back({8'd0, pt_mem[0]});
    for (int n = 1; n <= L; n++) begin
      exp_img[n] = pt_mem[n] ^ ks[n];
      exp_q.push_back({8'(n), exp_img[n]});
    end
  endtask

  task automatic load_rand_pt(input int L, input bit printable);
    pt_mem[0] = 8'(L);
    for (int a = 1; a < 256; a++)
      pt_mem[a] = printable ? 8'(32 + $urandom_range(0, 94))
                            : 8'($urandom);
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'hAA;
  endtask

  task automatic chk_img(input string nm);
    int bad;
    bad = -1;
    for (int a = 255; a >= 0; a--)
      if (ct_mem[a] !== exp_img[a]) bad = a;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: ct_mem[%0d] got %02h expected %02h",
               nm, bad, ct_mem[bad], exp_img[bad]);
    end
  endtask

  // Issues one accepted start; called at posedge+1 while idle.
  task automatic start(input logic [23:0] k);
    chk("start_rdy", 32'(rdy), 32'd1);
    key = k;
    en  = 1'b1;
    push_expected(k);
    @(posedge clk); #1;
    en = 1'b0;
    chk("accept_rdy_low", 32'(rdy), 32'd0);
    chk("first_s_wren", 32'(s_wren), 32'd1);
    chk("first_s_addr", 32'(s_addr), 32'd0);
    chk("first_s_wrdata", 32'(s_wrdata), 32'd0);
  endtask

  task automatic wait_done(input string nm, input int L, input int lim);
    int lat;
    lat = 0;
    while (!rdy && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_rdy"}, 32'(rdy), 32'd1);
    chk_le({nm, "_latency"}, lat, lim);
    chk_le({nm, "_latency_l"}, lat, 1806 + 10 * L);
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk_img({nm, "_image"});
  endtask

  initial begin
    int L, w0, a0, cyc, bad;
    logic [23:0] k1, k2;

    rst = 1'b1; en = 1'b0; key = 24'd0;
    for (int a = 0; a < 256; a++) begin
      pt_mem[a] = 8'd0; ct_mem[a] = 8'hAA; s_mem[a] = 8'd0;
    end
    #1;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_s_wren", 32'(s_wren), 32'd0);
    chk("rst_ct_wren", 32'(ct_wren), 32'd0);
    chk("rst_s_addr", 32'(s_addr), 32'd0);
    chk("rst_pt_addr", 32'(pt_addr), 32'd0);
    chk("rst_ct_addr", 32'(ct_addr), 32'd0);
    chk("rst_s_wrdata", 32'(s_wrdata), 32'd0);
    chk("rst_ct_wrdata", 32'(ct_wrdata), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of key scheduling.
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'd0;
    for (int a = 0; a < 10; a++) pt_mem[a] = std_pt[a];
    start(24'h4B6579);
    repeat (600) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rdy", 32'(rdy), 32'd1);
    chk("midrst_s_wren", 32'(s_wren), 32'd0);
    chk("midrst_ct_wren", 32'(ct_wren), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Standard vector.
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'hAA;
    start(24'h4B6579);
    wait_done("std", 9, 1896);
    for (int a = 0; a < 10; a++)
      chk($sformatf("std_ct%0d", a), 32'(ct_mem[a]), 32'(std_ct[a]));

    // Keystream with zero plaintext.
    for (int a = 0; a < 256; a++) begin
      pt_mem[a] = 8'd0; ct_mem[a] = 8'hAA;
    end
    pt_mem[0] = 8'h04;
    start(24'h4B6579);
    wait_done("ks", 4, 1846);
    for (int a = 0; a < 5; a++)
      chk($sformatf("ks_ct%0d", a), 32'(ct_mem[a]), 32'(ksv_ct[a]));
    bad = 0;
    for (int a = 5; a < 256; a++) if (ct_mem[a] !== 8'hAA) bad++;
    chk("ks_tail_untouched", 32'(bad), 32'd0);

    // Zero length.
    load_rand_pt(0, 1'b0);
    w0 = wren_cnt;
    start(24'($urandom));
    wait_done("zero", 0, 1800);
    chk("zero_wren_count", 32'(wren_cnt - w0), 32'd1);

    // en held high across two back-to-back runs.
    L = 20;
    load_rand_pt(L, 1'b0);
    k1 = 24'($urandom);
    k2 = k1 ^ 24'h5A3C01;
    a0 = acc_cnt;
    key = k1;
    en = 1'b1;
    push_expected(k1);
    @(posedge clk); #1;
    key = k2;
    push_expected(k2);
    cyc = 0;
    while ((acc_cnt - a0) < 2 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    en = 1'b0;
    chk("hs_accepts", 32'(acc_cnt - a0), 32'd2);
    chk_le("hs_gap", cyc, 1807 + 10 * L);
    checks++;
    if (cyc < 1792) begin
      failures++;
      $display("FAIL hs_gap_min: got %0d expected at least 1792", cyc);
    end
    wait_done("hs2", L, 1806 + 10 * L);

    // Round trip with a full-length printable message.
    load_rand_pt(255, 1'b1);
    start(24'h000018);
    wait_done("rt", 255, 1806 + 2550);
    gen_ks(24'h000018);
    bad = 0;
    for (int n = 1; n < 256; n++)
      if ((ct_mem[n] ^ ks[n]) !== pt_mem[n]) bad++;
    chk("rt_recovered", 32'(bad), 32'd0);
    chk("rt_len", 32'(ct_mem[0]), 32'd255);

    // Random keys and lengths.
    for (int r = 0; r < 3; r++) begin
      L = $urandom_range(1, 254);
      load_rand_pt(L, 1'b0);
      start(24'($urandom));
      wait_done($sformatf("rnd%0d", r), L, 1806 + 10 * L);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
